// File: rtl/bias_add_pkg.sv
// Shared types and fixed-point helpers for the bias-add / requantisation stage.
// The rounding helper is kept here so later requant stages can reuse it.
package bias_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SHIFT_W = 5;
    localparam int CALC_W  = 64;

    function automatic logic signed [CALC_W-1:0] sat_max(input int o_bw);
        return (64'sd1 <<< (o_bw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_min(input int o_bw);
        return -(64'sd1 <<< (o_bw - 1));
    endfunction

    // s must already be sign-extended from a w-bit value; shifts of w or more
    // collapse to the sign so the rounding constant cannot flip the result.
    function automatic logic signed [CALC_W-1:0] round_shift_sat(
        input logic signed [CALC_W-1:0] s,
        input logic [SHIFT_W-1:0]       shift,
        input int                       w,
        input int                       o_bw,
        input logic                     relu
    );
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] half;
        half = '0;
        if (shift == '0) begin
            r = s;
        end else if (int'(shift) >= w) begin
            r = s[CALC_W-1] ? -64'sd1 : 64'sd0;
        end else begin
            half = 64'sd1 <<< (shift - 5'd1);
            r    = (s + half) >>> shift;
        end
        if (r > sat_max(o_bw)) begin
            r = sat_max(o_bw);
        end else if (r < sat_min(o_bw)) begin
            r = sat_min(o_bw);
        end
        if (relu && r[CALC_W-1]) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/bias_add_relu_fifo.sv
// Synchronous FIFO with registered read data and an occupancy counter that
// distinguishes full from empty; used as the per-channel bias buffer.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = data_q;

    // A full FIFO still takes a word when the same cycle frees a slot.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define validity, and a resettable array would defeat RAM inference.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (do_pop) begin
            data_q <= mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/bias_add_relu.sv
// Pairs buffered bias words with accumulator results, then rounds, saturates
// and optionally rectifies them into a valid/ready activation stream.
module bias_add_relu
    import bias_add_pkg::*;
#(
    parameter int B_BW       = 8,
    parameter int ACC_BW     = 20,
    parameter int O_BW       = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_run,
    input  logic [CNT_W-1:0]  i_num_cnt,
    input  logic [4:0]        i_shift,
    input  logic              i_relu_en,
    input  logic              i_bias_valid,
    input  logic [B_BW-1:0]   i_bias,
    input  logic              i_acc_valid,
    output logic              o_acc_ready,
    input  logic [ACC_BW-1:0] i_acc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [O_BW-1:0]   o_data,
    output logic              o_idle,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_ovf
);

    localparam int W   = ACC_BW + 2;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic                    relu_q, relu_d;
    logic                    ovf_q, ovf_d;

    logic                    s1_valid_q;
    logic [ACC_BW-1:0]       s1_acc_q;
    logic                    o_valid_q;
    logic [O_BW-1:0]         o_data_q;

    logic                    fifo_push, fifo_pop, fifo_flush;
    logic                    fifo_full, fifo_empty;
    logic [FCW-1:0]          fifo_count_unused;
    logic [B_BW-1:0]         bias_rd;

    logic                    pipe_en;
    logic                    acc_accept;
    logic                    ovf_event;
    logic signed [W-1:0]     sum_w;
    logic signed [CALC_W-1:0] sum_ext;
    logic signed [CALC_W-1:0] rss;

    // Both stages advance together; a held output freezes the whole pipe.
    assign pipe_en     = !o_valid_q || i_ready;
    assign o_acc_ready = (state_q == ST_RUN) && !fifo_empty &&
                         (acc_cnt_q < cnt_q) && pipe_en;
    assign acc_accept  = i_acc_valid && o_acc_ready;

    assign fifo_push  = i_bias_valid && (state_q != ST_DONE);
    assign fifo_pop   = acc_accept;
    assign fifo_flush = (state_q == ST_DONE);
    assign ovf_event  = fifo_push && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH (B_BW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCW)
    ) u_bias_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (i_bias),
        .data_o  (bias_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        acc_cnt_d = acc_cnt_q + {{(CNT_W-1){1'b0}}, acc_accept};
        ovf_d     = ovf_q || ovf_event;
        case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    cnt_d     = i_num_cnt;
                    shift_d   = i_shift;
                    relu_d    = i_relu_en;
                    acc_cnt_d = '0;
                    ovf_d     = ovf_event;
                    state_d   = (i_num_cnt == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (acc_cnt_d == cnt_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !o_valid_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_cnt_q <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_cnt_q <= acc_cnt_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            ovf_q     <= ovf_d;
        end
    end

    // Stage 1 holds the accepted accumulator alongside the FIFO's registered
    // bias word; stage 2 sums, rounds and clamps into the output register.
    assign sum_w   = $signed({{2{s1_acc_q[ACC_BW-1]}}, s1_acc_q}) +
                     $signed({{(W-B_BW){bias_rd[B_BW-1]}}, bias_rd});
    assign sum_ext = {{(CALC_W-W){sum_w[W-1]}}, sum_w};
    assign rss     = round_shift_sat(sum_ext, shift_q, W, O_BW, relu_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_acc_q   <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
        end else if (pipe_en) begin
            s1_valid_q <= acc_accept;
            if (acc_accept) s1_acc_q <= i_acc;
            o_valid_q  <= s1_valid_q;
            if (s1_valid_q) o_data_q <= rss[O_BW-1:0];
        end
    end

    assign o_valid   = o_valid_q;
    assign o_data    = o_data_q;
    assign o_idle    = (state_q == ST_IDLE);
    assign o_busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done    = (state_q == ST_DONE);
    assign o_err_ovf = ovf_q;

endmodule

// File: tb/tb_bias_add_relu.sv
// Self-checking bench: randomized traffic scored against a plain-arithmetic
// reference of the bias/round/saturate/ReLU rules.
module tb_bias_add_relu;

    localparam int CNT_W = 16;
    localparam int DEPTH = 64;
    localparam int WBITS = 22;

    logic               clk, rst_n, i_run;
    logic [CNT_W-1:0]   i_num_cnt;
    logic [4:0]         i_shift;
    logic               i_relu_en, i_bias_valid, i_acc_valid, i_ready;
    logic signed [7:0]  i_bias;
    logic signed [19:0] i_acc;
    logic               o_acc_ready, o_valid, o_idle, o_busy, o_done, o_err_ovf;
    logic signed [7:0]  o_data;

    bias_add_relu dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_shift(i_shift), .i_relu_en(i_relu_en), .i_bias_valid(i_bias_valid),
        .i_bias(i_bias), .i_acc_valid(i_acc_valid), .o_acc_ready(o_acc_ready),
        .i_acc(i_acc), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done), .o_err_ovf(o_err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic signed [7:0]  exp_q[$];
    logic signed [7:0]  bias_q[$];
    logic signed [7:0]  out_log[$];
    logic signed [7:0]  bias_src[$];
    logic signed [19:0] acc_src[$];
    int   done_cnt = 0;
    int   out_cnt  = 0;
    bit   acc_taken;
    bit   stall_prev;
    logic signed [7:0] prev_data;
    int   m_shift;
    bit   m_relu;
    bit   m_ovf;

    function automatic logic signed [7:0] ref_q(input longint acc, input longint bias,
                                                input int sh, input bit relu);
        longint s, r, p;
        s = acc + bias;
        if (sh == 0) begin
            r = s;
        end else if (sh >= WBITS) begin
            r = (s < 0) ? -1 : 0;
        end else begin
            p = longint'(1) << sh;
            r = s + p / 2;
            r = (r >= 0) ? r / p : -((-r + p - 1) / p);
        end
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
        if (relu && r < 0) r = 0;
        return 8'(r);
    endfunction

    task automatic cycle(input bit run, input bit bv, input logic signed [7:0] b,
                         input bit av, input logic signed [19:0] a, input bit rdy);
        logic signed [7:0] e;
        bit popped;
        i_run = run; i_bias_valid = bv; i_bias = b;
        i_acc_valid = av; i_acc = a; i_ready = rdy;
        @(negedge clk);
        acc_taken = 1'b0;
        popped    = 1'b0;
        if (stall_prev) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== prev_data) begin
                errors++;
                $display("FAIL stall_hold: o_valid=%b o_data=%0d, required held value %0d", o_valid, o_data, prev_data);
            end
        end
        if (o_valid === 1'b1 && rdy) begin
            checks++;
            out_cnt++;
            out_log.push_back(o_data);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: o_data=%0d with nothing outstanding", o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    errors++;
                    $display("FAIL out_data: got %0d, required %0d", o_data, e);
                end
            end
        end
        if (o_done === 1'b1) begin
            done_cnt++;
            bias_q.delete();
        end
        if (av && o_acc_ready === 1'b1) begin
            acc_taken = 1'b1;
            popped    = 1'b1;
            if (bias_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept_without_bias: accepted acc=%0d, required no acceptance", a);
            end else begin
                exp_q.push_back(ref_q(a, bias_q.pop_front(), m_shift, m_relu));
            end
        end
        if (bv && o_done !== 1'b1) begin
            if (bias_q.size() >= DEPTH) m_ovf = 1'b1;
            else bias_q.push_back(b);
        end
        stall_prev = (o_valid === 1'b1) && !rdy;
        prev_data  = o_data;
        @(posedge clk);
        #1;
        i_run = 1'b0;
    endtask

    task automatic preload(input int n_words);
        for (int i = 0; i < n_words; i++) cycle(0, 1, bias_src[i], 0, '0, 1);
        bias_src.delete();
    endtask

    task automatic run_job(input int n, input int sh, input bit relu, input bit rand_ready,
                           input string name);
        int idx, budget, out0;
        bit bv, av, rdy;
        logic signed [7:0]  b;
        logic signed [19:0] a;
        idx = 0; budget = 0; out0 = out_cnt;
        out_log.delete();
        i_num_cnt = CNT_W'(n); i_shift = 5'(sh); i_relu_en = relu;
        m_shift = sh; m_relu = relu; m_ovf = 1'b0;
        cycle(1, 0, '0, 0, '0, 1);
        while (done_cnt == 0 && budget < 3000) begin
            if (bias_src.size() > 0 && $urandom_range(1, 0) == 1) begin
                bv = 1'b1; b = bias_src.pop_front();
            end else begin
                bv = 1'b0; b = '0;
            end
            av  = (idx < n) && ($urandom_range(3, 0) != 0);
            a   = av ? acc_src[idx] : 20'($urandom);
            rdy = rand_ready ? ($urandom_range(1, 0) == 1) : 1'b1;
            cycle(0, bv, b, av, a, rdy);
            if (acc_taken) idx++;
            budget++;
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s_done: saw %0d done pulses, required 1 within budget", name, done_cnt);
        end
        checks++;
        if (out_cnt - out0 != n || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_count: outputs=%0d pending=%0d, required %0d and 0", name, out_cnt - out0, exp_q.size(), n);
        end
        checks++;
        if (o_err_ovf !== m_ovf) begin
            errors++;
            $display("FAIL %s_ovf: o_err_ovf=%b, required %b", name, o_err_ovf, m_ovf);
        end
        cycle(0, 0, '0, 0, '0, 1);
        checks++;
        if (o_done !== 1'b0 || o_idle !== 1'b1 || done_cnt != 1) begin
            errors++;
            $display("FAIL %s_return_idle: o_done=%b o_idle=%b pulses=%0d, required 0 1 1", name, o_done, o_idle, done_cnt);
        end
        done_cnt = 0;
        bias_src.delete();
        acc_src.delete();
    endtask

    task automatic check_fixed(input string name, input int n, input logic signed [7:0] e0,
                               input logic signed [7:0] e1, input logic signed [7:0] e2,
                               input logic signed [7:0] e3);
        logic signed [7:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (i >= out_log.size()) begin
                errors++;
                $display("FAIL %s_fixed%0d: missing output, required %0d", name, i, ev[i]);
            end else if (out_log[i] !== ev[i]) begin
                errors++;
                $display("FAIL %s_fixed%0d: got %0d, required %0d", name, i, out_log[i], ev[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_run = 0; i_num_cnt = '0; i_shift = '0; i_relu_en = 0;
        i_bias_valid = 0; i_bias = '0; i_acc_valid = 0; i_acc = '0; i_ready = 1;
        stall_prev = 1'b0; prev_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_acc_ready, o_valid, o_idle, o_busy, o_done, o_err_ovf} !== 6'b001000) begin
            errors++;
            $display("FAIL reset_flags: ready,valid,idle,busy,done,ovf=%b, required 001000",
                     {o_acc_ready, o_valid, o_idle, o_busy, o_done, o_err_ovf});
        end
        checks++;
        if (o_data !== 8'sd0) begin
            errors++;
            $display("FAIL reset_data: o_data=%0d, required 0", o_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bias_src = '{8'sd10, -8'sd5, 8'sd0, 8'sd127};
        preload(4);
        acc_src = '{20'sd100, -20'sd100, 20'sd27, 20'sd0};
        run_job(4, 0, 0, 0, "basic");
        check_fixed("basic", 4, 8'sd110, -8'sd105, 8'sd27, 8'sd127);
    endtask

    task automatic test_rounding();
        bias_src = '{8'sd0, 8'sd0, 8'sd0};
        preload(3);
        acc_src = '{20'sd13, -20'sd14, 20'sd14};
        run_job(3, 2, 0, 0, "round");
        check_fixed("round", 3, 8'sd3, -8'sd3, 8'sd4, 8'sd0);
    endtask

    task automatic test_relu_sat();
        bias_src = '{8'sd20};
        preload(1);
        acc_src = '{-20'sd300};
        run_job(1, 0, 1, 0, "relu");
        check_fixed("relu", 1, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
        bias_src = '{8'sd0};
        preload(1);
        acc_src = '{20'sd300};
        run_job(1, 1, 1, 0, "sat");
        check_fixed("sat", 1, 8'sd127, 8'sd0, 8'sd0, 8'sd0);
        bias_src = '{8'sd0, 8'sd0};
        preload(2);
        acc_src = '{-20'sd5, 20'sd5};
        run_job(2, 25, 0, 0, "bigshift");
        check_fixed("bigshift", 2, -8'sd1, 8'sd0, 8'sd0, 8'sd0);
    endtask

    task automatic test_random_stall();
        for (int i = 0; i < 49; i++) begin
            bias_src.push_back(8'($urandom));
            acc_src.push_back(20'($urandom));
        end
        run_job(49, int'($urandom_range(12, 0)), bit'($urandom_range(1, 0)), 1, "random");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 65; i++) cycle(0, 1, 8'($urandom), 0, '0, 1);
        checks++;
        if (o_err_ovf !== m_ovf || m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: o_err_ovf=%b, required 1", o_err_ovf);
        end
        for (int i = 0; i < DEPTH; i++) acc_src.push_back(20'($urandom_range(2000, 0)) - 20'sd1000);
        run_job(DEPTH, 0, 0, 0, "retained");
        i_num_cnt = '0;
        cycle(1, 0, '0, 0, '0, 1);
        checks++;
        if (o_done !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_count: done=%b valid=%b busy=%b, required 1 0 0", o_done, o_valid, o_busy);
        end
        cycle(0, 0, '0, 0, '0, 1);
        checks++;
        if (o_idle !== 1'b1 || o_done !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_count_idle: idle=%b done=%b valid=%b, required 1 0 0", o_idle, o_done, o_valid);
        end
        done_cnt = 0;
    endtask

    task automatic test_reset_mid();
        int idx, budget, out0, done0;
        bit taken_any;
        logic signed [19:0] a;
        for (int i = 0; i < 8; i++) begin
            bias_src.push_back(8'($urandom));
            acc_src.push_back(20'($urandom_range(400, 0)));
        end
        preload(8);
        i_num_cnt = CNT_W'(8); i_shift = '0; i_relu_en = 0;
        m_shift = 0; m_relu = 0;
        cycle(1, 0, '0, 0, '0, 1);
        idx = 0; budget = 0; out0 = out_cnt;
        while (out_cnt - out0 < 3 && budget < 200) begin
            a = (idx < 8) ? acc_src[idx] : '0;
            cycle(0, 0, '0, idx < 8, a, 1);
            if (acc_taken) idx++;
            budget++;
        end
        checks++;
        if (out_cnt - out0 != 3) begin
            errors++;
            $display("FAIL midrun_progress: %0d outputs, required 3", out_cnt - out0);
        end
        i_acc_valid = 0; i_bias_valid = 0; done0 = done_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete(); bias_q.delete(); acc_src.delete(); stall_prev = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_idle !== 1'b1 || o_done !== 1'b0 || o_acc_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: valid=%b idle=%b done=%b ready=%b, required 0 1 0 0", o_valid, o_idle, o_done, o_acc_ready);
        end
        i_num_cnt = CNT_W'(1);
        cycle(1, 0, '0, 0, '0, 1);
        taken_any = 1'b0;
        repeat (4) begin
            cycle(0, 0, '0, 1, 20'sd5, 1);
            taken_any |= acc_taken;
        end
        checks++;
        if (taken_any || done_cnt != done0) begin
            errors++;
            $display("FAIL fifo_empty_after_reset: accepted=%b done_pulses=%0d, required 0 0", taken_any, done_cnt - done0);
        end
        i_acc_valid = 0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete(); bias_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_relu_sat();
        test_random_stall();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
